// File: rtl/start_pkg.sv
// Shared definitions for the start-table loader: register field positions,
// bus control bits and the loader state encoding.
package start_pkg;

    localparam int START_TBL_LSB   = 0;
    localparam int START_TBL_MSB   = 5;
    localparam int START_MODE_BIT  = 6;
    localparam int START_ARMED_BIT = 7;

    localparam int START_CTRL_SET_TABLE = 0;
    localparam int START_CTRL_SET_ARMED = 1;
    localparam int START_CTRL_SET_MODE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_OUT  = 2'd3
    } start_state_e;

    // Write word that clears only the armed bit: ctrl in [15:8], data in [7:0].
    function automatic logic [15:0] disarm_word();
        logic [7:0] ctrl;
        ctrl = '0;
        ctrl[START_CTRL_SET_ARMED] = 1'b1;
        return {ctrl, 8'h00};
    endfunction

endpackage

// File: rtl/start_loader.sv
// Start-table loader: reads the start-table register, optionally disarms it,
// and hands the decoded selection over tbl_valid/tbl_ready. Macro START_LDR_TIMEOUT_EN adds an ack timeout.
module start_loader
    import start_pkg::*;
#(
    parameter bit          DISARM      = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        m_stb,
    output logic        m_we,
    output logic [15:0] m_dout,
    input  logic [31:0] m_din,
    input  logic        m_ack,
    output logic        tbl_valid,
    input  logic        tbl_ready,
    output logic [5:0]  tbl_no,
    output logic        tbl_mode,
    output logic        tbl_armed,
    output logic        busy,
    output logic        err
);

    // tbl_valid/tbl_ready: a selection transfers on any rising edge where both are 1;
    // once raised, tbl_valid and tbl_* hold until that transfer.
    start_state_e state_q, state_d;
    logic         start_q, start_d;
    logic         stb_q, we_q, valid_q;
    logic [15:0]  dout_q;
    logic [5:0]   tbl_no_q, tbl_no_d;
    logic         tbl_mode_q, tbl_mode_d;
    logic         tbl_armed_q, tbl_armed_d;
    logic         timeout;
    logic         err_set, err_clr;

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        tbl_no_d    = tbl_no_q;
        tbl_mode_d  = tbl_mode_q;
        tbl_armed_d = tbl_armed_q;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_q || go) begin
                    state_d = ST_RD;
                    start_d = 1'b0;
                    err_clr = 1'b1;
                end
            end
            ST_RD: begin
                if (m_ack) begin
                    tbl_no_d    = m_din[START_TBL_MSB:START_TBL_LSB];
                    tbl_mode_d  = m_din[START_MODE_BIT];
                    tbl_armed_d = m_din[START_ARMED_BIT];
                    state_d     = (DISARM && m_din[START_ARMED_BIT]) ? ST_WR : ST_OUT;
                end else if (timeout) begin
                    tbl_no_d    = '0;
                    tbl_mode_d  = 1'b0;
                    tbl_armed_d = 1'b0;
                    err_set     = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_WR: begin
                // tbl_* keep the pre-disarm values that were read.
                if (m_ack) begin
                    state_d = ST_OUT;
                end else if (timeout) begin
                    tbl_no_d    = '0;
                    tbl_mode_d  = 1'b0;
                    tbl_armed_d = 1'b0;
                    err_set     = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (tbl_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and handshake outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b1;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            tbl_no_q    <= '0;
            tbl_mode_q  <= 1'b0;
            tbl_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stb_q       <= (state_d == ST_RD) || (state_d == ST_WR);
            we_q        <= (state_d == ST_WR);
            dout_q      <= (state_d == ST_WR) ? disarm_word() : 16'h0000;
            valid_q     <= (state_d == ST_OUT);
            tbl_no_q    <= tbl_no_d;
            tbl_mode_q  <= tbl_mode_d;
            tbl_armed_q <= tbl_armed_d;
        end
    end

`ifdef START_LDR_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    assign timeout = ((state_q == ST_RD) || (state_q == ST_WR)) &&
                     (cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
            if (err_clr)      err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;
    assign timeout    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = ^{err_set, err_clr, 16'(TIMEOUT_CYC)};
`endif

    logic unused_din;
    assign unused_din = ^m_din[31:8];

    assign m_stb     = stb_q;
    assign m_we      = we_q;
    assign m_dout    = dout_q;
    assign tbl_valid = valid_q;
    assign tbl_no    = tbl_no_q;
    assign tbl_mode  = tbl_mode_q;
    assign tbl_armed = tbl_armed_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_start_loader.sv
// Randomized scoreboard bench for start_loader: a behavioural start-table register
// answers the bus, and every handed-over selection is checked against queued predictions.
module tb_start_loader;

    logic        clk = 1'b0;
    logic        rst, go;
    logic        m_stb, m_we, m_ack;
    logic [15:0] m_dout;
    logic [31:0] m_din;
    logic        tbl_valid, tbl_ready;
    logic [5:0]  tbl_no;
    logic        tbl_mode, tbl_armed, busy, err;

    always #5 clk = ~clk;

`ifdef START_LDR_TIMEOUT_EN
    start_loader #(.DISARM(1'b1), .TIMEOUT_CYC(8)) dut (
`else
    start_loader #(.DISARM(1'b1)) dut (
`endif
        .clk(clk), .rst(rst), .go(go),
        .m_stb(m_stb), .m_we(m_we), .m_dout(m_dout), .m_din(m_din), .m_ack(m_ack),
        .tbl_valid(tbl_valid), .tbl_ready(tbl_ready), .tbl_no(tbl_no),
        .tbl_mode(tbl_mode), .tbl_armed(tbl_armed), .busy(busy), .err(err)
    );

    // Register model: byte {armed, mode, table_no}; upper read bits are noise.
    logic [7:0]  reg_val;
    logic [23:0] din_hi;
    assign m_din = {din_hi, reg_val};

    bit          ack_en;
    int          min_dly, max_dly, cur_dly, wcnt;
    int          n_rd, n_wr;
    logic        hold_we;
    logic [15:0] hold_dout;
    int          ready_mode;

    logic [7:0] exp_q[$];
    int         exp_rd_q[$];
    int         exp_wr_q[$];
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bus slave: acks after cur_dly waiting cycles, applies writes to the register model.
    always @(negedge clk) begin
        if (rst || !m_stb) begin
            m_ack = 1'b0;
            wcnt  = 0;
        end else begin
            if (wcnt == 0) begin
                hold_we   = m_we;
                hold_dout = m_dout;
            end else begin
                check("bus_hold", {15'd0, m_we, m_dout}, {15'd0, hold_we, hold_dout});
            end
            if (ack_en && wcnt >= cur_dly) begin
                m_ack = 1'b1;
                if (m_we) begin
                    n_wr++;
                    check("wr_data", {16'd0, m_dout}, 32'h0000_0200);
                    if (m_dout[8])  reg_val[5:0] = m_dout[5:0];
                    if (m_dout[9])  reg_val[7]   = m_dout[7];
                    if (m_dout[10]) reg_val[6]   = m_dout[6];
                end else begin
                    n_rd++;
                    check("rd_dout", {16'd0, m_dout}, 32'd0);
                end
                wcnt    = 0;
                cur_dly = $urandom_range(max_dly, min_dly);
            end else begin
                m_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: drive ready for the coming edge, then score the transfer that edge will take.
    always @(negedge clk) begin
        case (ready_mode)
            1:       tbl_ready = 1'b0;
            2:       tbl_ready = 1'b1;
            default: tbl_ready = 1'($urandom_range(1, 0));
        endcase
        if (!rst && tbl_valid && tbl_ready) begin
            if (exp_q.size() == 0) begin
                note_fail("unexpected_out");
            end else begin
                check("tbl_fields", {24'd0, tbl_armed, tbl_mode, tbl_no}, {24'd0, exp_q.pop_front()});
                check("reads_per_load", n_rd, exp_rd_q.pop_front());
                check("writes_per_load", n_wr, exp_wr_q.pop_front());
            end
            n_rd = 0;
            n_wr = 0;
        end
    end

    task automatic push_exp(input logic [7:0] fields, input int rd, input int wr);
        exp_q.push_back(fields);
        exp_rd_q.push_back(rd);
        exp_wr_q.push_back(wr);
    endtask

    // Issue a load from IDLE; DISARM=1 so an armed read implies one write.
    task automatic issue_go();
        go = 1'b1;
        push_exp(reg_val, 1, reg_val[7] ? 1 : 0);
        step();
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) note_fail(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; go = 1'b0;
        ack_en = 1'b1; min_dly = 0; max_dly = 0; cur_dly = 0; wcnt = 0;
        n_rd = 0; n_wr = 0; ready_mode = 2; tbl_ready = 1'b0; m_ack = 1'b0;
        reg_val = 8'h85; din_hi = 24'($urandom);
        repeat (3) step();
        check("reset_outs", {m_stb, m_we, m_dout, tbl_valid, tbl_no, tbl_mode, tbl_armed, busy, err}, 32'd0);

        // Automatic post-reset load of an armed entry with combinational ack.
        push_exp(8'h85, 1, 1);
        rst = 1'b0;
        step();
        check("auto_rd", {m_stb, m_we, m_dout}, {1'b1, 1'b0, 16'h0000});
        step();
        check("auto_wr", {m_stb, m_we, m_dout}, {1'b1, 1'b1, 16'h0200});
        step();
        check("auto_latency", {31'd0, tbl_valid}, 32'd1);
        wait_idle("idle_auto");
        check("model_disarmed", {24'd0, reg_val}, 32'h05);

        // Unarmed entry: no write, register untouched.
        reg_val = 8'h45;
        issue_go();
        wait_idle("idle_unarmed");
        check("model_unarmed", {24'd0, reg_val}, 32'h45);

        // Consumer stalls for 10 cycles; go pulses must be ignored.
        ready_mode = 1;
        reg_val = 8'h9A;
        issue_go();
        begin
            int n;
            n = 0;
            while (!tbl_valid && n < 50) begin step(); n++; end
            if (n >= 50) note_fail("stall_valid");
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {22'd0, tbl_valid, busy, tbl_armed, tbl_mode, tbl_no}, {22'd0, 2'b11, 8'h9A});
            go = (i % 3 == 0);
            step();
        end
        go = 1'b0;
        ready_mode = 2;
        step();
        step();
        check("idle_after_ready", {30'd0, busy, tbl_valid}, 32'd0);

        // Reset while the read waits for ack: strobe must drop, no write.
        ack_en = 1'b0;
        reg_val = 8'hA3;
        issue_go();
        step();
        check("rd_waiting", {30'd0, m_stb, m_we}, 32'd2);
        rst = 1'b1;
        step();
        check("rst_abort", {30'd0, m_stb, busy}, 32'd0);
        check("rst_no_write", n_wr, 0);
        exp_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
        n_rd = 0; n_wr = 0;
        ack_en = 1'b1;
        push_exp(8'hA3, 1, 1);
        rst = 1'b0;
        wait_idle("idle_after_rst");
        check("rst_reload_disarmed", {24'd0, reg_val}, 32'h23);

        // Acks delayed three cycles in both bus phases.
        min_dly = 3; max_dly = 3; cur_dly = 3;
        reg_val = 8'hC7;
        issue_go();
        wait_idle("idle_slow_ack");
        check("slow_ack_disarmed", {24'd0, reg_val}, 32'h47);

`ifdef START_LDR_TIMEOUT_EN
        // No ack at all: aborts to an all-zero selection and sets err.
        ack_en = 1'b0;
        go = 1'b1;
        push_exp(8'h00, 0, 0);
        step();
        go = 1'b0;
        begin
            int n;
            n = 0;
            while (!tbl_valid && n < 50) begin step(); n++; end
            if (n >= 50) note_fail("timeout_valid");
        end
        check("timeout_err", {31'd0, err}, 32'd1);
        wait_idle("idle_timeout");
        ack_en = 1'b1;
        reg_val = 8'h12;
        issue_go();
        check("err_cleared", {31'd0, err}, 32'd0);
        wait_idle("idle_after_timeout");
`endif

        // Random loads, random ack delays and consumer backpressure.
        min_dly = 0; max_dly = 3; ready_mode = 0;
        for (int k = 0; k < 25; k++) begin
            reg_val = 8'($urandom);
            din_hi  = 24'($urandom);
            issue_go();
            if (k % 2 == 0) begin
                go = 1'b1;
                step();
                go = 1'b0;
            end
            wait_idle("idle_random");
        end
        check("final_err", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
